ws2812_segment_driver: RTL and testbench

- Downstream consumer of display_decoder; drives a WS2812-style addressable LED chain in which each LED is one display segment.
- Per LED: samples the decoder's led_data bit and pulses next_led to advance it. Serialises ON_COLOR or OFF_COLOR as 24-bit GRB, MSB first, with one-wire NRZ timing.
- Ends every frame with a low latch interval.

---
 rtl/ws2812_segment_driver_if.sv | 25 ++
 rtl/ws2812_segment_driver.sv | 129 ++++++++++++
 tb/tb_ws2812_segment_driver.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/ws2812_segment_driver_if.sv
// Frame request / LED data bundle between a decoder owner and
// the WS2812 segment driver.
interface ws2812_segment_driver_if;
  logic start;
  logic led_data;
  logic next_led;
  logic dout;
  logic busy;

  modport master (
    output start,
    output led_data,
    input  next_led,
    input  dout,
    input  busy
  );

  modport slave (
    input  start,
    input  led_data,
    output next_led,
    output dout,
    output busy
  );
endinterface

// File: rtl/ws2812_segment_driver.sv
// WS2812 chain driver: one LED per display segment, GRB MSB first,
// NRZ one-wire timing, low latch interval after every frame.
module ws2812_segment_driver #(
  parameter int          LED_COUNT = 28,
  parameter int          T0H_CYC   = 20,
  parameter int          T1H_CYC   = 40,
  parameter int          BIT_CYC   = 63,
  parameter int          RESET_CYC = 2750,
  parameter logic [23:0] ON_COLOR  = 24'h00FF00,
  parameter logic [23:0] OFF_COLOR = 24'h000000
) (
  input logic clk,
  input logic rst,
  ws2812_segment_driver_if.slave bus
);

  localparam int TMAX = (BIT_CYC > RESET_CYC) ? BIT_CYC : RESET_CYC;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int LW   = $clog2(LED_COUNT + 1);

  localparam logic [TW-1:0] T0_LAST    = TW'(T0H_CYC - 1);
  localparam logic [TW-1:0] T1_LAST    = TW'(T1H_CYC - 1);
  localparam logic [TW-1:0] BIT_LAST   = TW'(BIT_CYC - 1);
  localparam logic [TW-1:0] RESET_LAST = TW'(RESET_CYC - 1);
  localparam logic [LW-1:0] LED_LAST   = LW'(LED_COUNT - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HIGH,
    LOW,
    LATCH
  } state_t;

  state_t        state;
  state_t        state_n;
  logic          busy_q;
  logic [23:0]   shift_reg;
  logic [TW-1:0] tcnt;
  logic [4:0]    bit_cnt;
  logic [LW-1:0] led_cnt;

  logic [TW-1:0] high_last;
  logic          bit_done;
  logic          last_bit;
  logic          last_led;

  assign high_last = shift_reg[23] ? T1_LAST : T0_LAST;
  assign bit_done  = (tcnt == BIT_LAST);
  assign last_bit  = (bit_cnt == 5'd23);
  assign last_led  = (led_cnt == LED_LAST);

  // State register; busy is held one cycle past the return to IDLE
  // so a frame occupies exactly LED/bit/latch time plus one cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      busy_q <= 1'b0;
    end else begin
      state  <= state_n;
      busy_q <= (state != IDLE) || (state_n != IDLE);
    end
  end

  // Next-state decode of the bit/LED/latch sequencing.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (bus.start) state_n = LOAD;
      LOAD:  state_n = HIGH;
      HIGH:  if (tcnt == high_last) state_n = LOW;
      LOW: begin
        if (bit_done) begin
          if (!last_bit)     state_n = HIGH;
          else if (last_led) state_n = LATCH;
          else               state_n = LOAD;
        end
      end
      LATCH: if (tcnt == RESET_LAST) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are pure decodes of the state flop, so they are glitch
  // free and change only at clock edges.
  always_comb begin
    bus.next_led = (state == LOAD);
    bus.dout     = (state == HIGH);
    bus.busy     = busy_q;
  end

  // Shift register and counters; led_data is captured in LOAD, the
  // same edge at which the decoder advances on next_led.
  always_ff @(posedge clk) begin
    if (!rst) begin
      shift_reg <= '0;
      tcnt      <= '0;
      bit_cnt   <= '0;
      led_cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          tcnt    <= '0;
          bit_cnt <= '0;
          if (bus.start) led_cnt <= '0;
        end
        LOAD: begin
          shift_reg <= bus.led_data ? ON_COLOR : OFF_COLOR;
          bit_cnt   <= '0;
          tcnt      <= '0;
        end
        HIGH: tcnt <= tcnt + 1'b1;
        LOW: begin
          if (bit_done) begin
            tcnt      <= '0;
            shift_reg <= {shift_reg[22:0], 1'b0};
            bit_cnt   <= bit_cnt + 5'd1;
            if (last_bit) led_cnt <= led_cnt + 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        LATCH: tcnt <= (tcnt == RESET_LAST) ? '0 : tcnt + 1'b1;
        default: tcnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_segment_driver.sv
// Directed bench: decoder model feeds segments, a dout decoder
// checks bit timing and GRB words against a scoreboard queue.
module tb_ws2812_segment_driver;

  localparam int          NLED  = 7;
  localparam logic [23:0] ON_C  = 24'h00FF00;
  localparam logic [23:0] OFF_C = 24'h000000;
  localparam int FRAME = NLED * (1 + 24 * 63) + 2750 + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;

  ws2812_segment_driver_if bus ();

  ws2812_segment_driver #(
    .LED_COUNT(NLED),
    .T0H_CYC  (20),
    .T1H_CYC  (40),
    .BIT_CYC  (63),
    .RESET_CYC(2750),
    .ON_COLOR (ON_C),
    .OFF_COLOR(OFF_C)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Decoder model: segment index advances on next_led.
  logic [6:0] pat = 7'h7F;
  int         idx = 0;
  always @(posedge clk) begin
    if (!rst)              idx <= 0;
    else if (bus.next_led) idx <= (idx == 6) ? 0 : idx + 1;
  end
  assign bus.led_data = pat[idx];

  logic [23:0] sb[$];

  task automatic push_frame(input logic [6:0] p);
    for (int i = 0; i < NLED; i++) sb.push_back(p[i] ? ON_C : OFF_C);
  endtask

  // Line monitor: measures high time and bit period, rebuilds words.
  logic        pd = 1'b0;
  logic        pn = 1'b0;
  logic        have_rise = 1'b0;
  int          last_rise = 0;
  int          fall_c = -1000;
  int          bit_pos = 0;
  int          nl_total = 0;
  logic [23:0] word = '0;

  always @(negedge clk) begin
    int   h;
    logic eb;
    if (!rst) begin
      pd = 1'b0; pn = 1'b0; have_rise = 1'b0;
      bit_pos = 0; word = '0;
    end else begin
      if (bus.next_led) begin
        check("next_led_width", int'(pn), 0);
        nl_total++;
      end
      pn = bus.next_led;
      if (bus.dout && !pd) begin
        if (have_rise && (cyc - fall_c) < 100)
          check("bit_period", cyc - last_rise, (bit_pos == 0) ? 64 : 63);
        else
          check("frame_align", bit_pos, 0);
        last_rise = cyc;
        have_rise = 1'b1;
      end
      if (!bus.dout && pd) begin
        h = cyc - last_rise;
        fall_c = cyc;
        if (sb.size() == 0) begin
          check("unexpected_bit", 1, 0);
        end else begin
          eb = sb[0][23 - bit_pos];
          check("high_len", h, eb ? 40 : 20);
          word = {word[22:0], (h > 30)};
          bit_pos++;
          if (bit_pos == 24) begin
            check("grb_word", int'(word), int'(sb.pop_front()));
            bit_pos = 0;
          end
        end
      end
      pd = bus.dout;
    end
  end

  task automatic wait_busy(input logic lvl, input int bound, output int t);
    int n;
    n = 0;
    while (bus.busy !== lvl && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("busy_wait", int'(bus.busy === lvl), 1);
    t = cyc;
  endtask

  task automatic wait_nl(input int target, input int bound, output int t);
    int n;
    n = 0;
    while (nl_total < target && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("next_led_wait", int'(nl_total >= target), 1);
    t = cyc;
  endtask

  task automatic run_frame(input logic [6:0] p, input bit poke);
    int t0, t1, base;
    pat = p;
    push_frame(p);
    base = nl_total;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    wait_busy(1'b1, 5, t0);
    if (poke) begin
      repeat (3000) @(negedge clk);
      bus.start = 1'b1;
      repeat (50) @(negedge clk);
      bus.start = 1'b0;
    end
    wait_busy(1'b0, FRAME + 100, t1);
    check("frame_len", t1 - t0, FRAME);
    check("latch_gap", t1 - fall_c, 43 + 2750 + 1);
    check("next_led_count", nl_total - base, NLED);
    check("sb_drained", sb.size(), 0);
    repeat (20) @(negedge clk);
    check("no_second_frame", int'(bus.busy), 0);
  endtask

  initial begin
    int t1, t8, base, tb_;
    bus.start = 1'b1;
    rst = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_dout", int'(bus.dout), 0);
      check("rst_next_led", int'(bus.next_led), 0);
      check("rst_busy", int'(bus.busy), 0);
    end
    bus.start = 1'b0;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_busy", int'(bus.busy), 0);

    // digit 8, with start poked mid-frame
    run_frame(7'h7F, 1'b1);
    // digit 1: OFF ON OFF OFF OFF OFF ON
    run_frame(7'b1000010, 1'b0);

    // reset during LED 3 bit 10 high phase
    pat = 7'h7F;
    push_frame(pat);
    base = nl_total;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    tb_ = 0;
    while (!(nl_total == base + 4 && bit_pos == 10 && bus.dout)
           && tb_ < 20000) begin
      @(negedge clk);
      tb_++;
    end
    check("mid_reset_reached", int'(tb_ < 20000), 1);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_dout", int'(bus.dout), 0);
    check("mid_rst_busy", int'(bus.busy), 0);
    sb.delete();
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // back-to-back frames from a held start
    pat = 7'b1000010;
    push_frame(pat);
    push_frame(pat);
    base = nl_total;
    bus.start = 1'b1;
    wait_nl(base + 1, 10, t1);
    wait_nl(base + 8, FRAME + 100, t8);
    bus.start = 1'b0;
    check("b2b_spacing", t8 - t1, FRAME);
    wait_busy(1'b0, FRAME + 100, tb_);
    check("b2b_next_led", nl_total - base, 2 * NLED);
    check("b2b_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
